// File: rtl/ant_sched.sv
// Round-robin ant mover: on each vblank rising edge, requests a move for every ant in turn
// from a shared move engine and applies the clamped step to that ant's position.
module ant_sched #(
  parameter int N_ANTS  = 4,
  parameter int STEP    = 5,
  parameter int TIMEOUT = 16,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 615,
  parameter int Y_MIN   = 240,
  parameter int Y_MAX   = 455
) (
  input  logic                      CLK,
  input  logic                      RST_BTN,
  input  logic                      vblank,
  input  logic                      ack,
  input  logic                      move_en,
  input  logic [1:0]                dir,
  input  logic                      err_clr,
  output logic                      req,
  output logic [$clog2(N_ANTS)-1:0] req_id,
  output logic                      busy,
  output logic                      round_done,
  output logic [10*N_ANTS-1:0]      ant_x,
  output logic [9*N_ANTS-1:0]       ant_y,
  output logic                      err_timeout,
  output logic                      err_overrun
);

  localparam int IW = $clog2(N_ANTS);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StWait, StApply} state_e;

  state_e        state_q;
  logic          vblank_q;
  logic [CW-1:0] wait_cnt_q;
  logic [1:0]    dir_q;
  logic          move_q;
  logic [9:0]    x_q [N_ANTS];
  logic [8:0]    y_q [N_ANTS];

  logic          rise;
  logic [9:0]    cur_x, new_x;
  logic [8:0]    cur_y, new_y;

  assign rise = vblank & ~vblank_q;

  // Bounds are checked in widened arithmetic so a step never wraps past a clamp.
  always_comb begin
    cur_x = x_q[req_id];
    cur_y = y_q[req_id];
    new_x = cur_x;
    new_y = cur_y;
    if (move_q) begin
      case (dir_q)
        2'b00: new_x = ({2'b00, cur_x} + 12'(STEP) > 12'(X_MAX)) ? 10'(X_MAX) : cur_x + 10'(STEP);
        2'b01: new_x = ({2'b00, cur_x} < 12'(X_MIN + STEP)) ? 10'(X_MIN) : cur_x - 10'(STEP);
        2'b10: new_y = ({2'b00, cur_y} + 11'(STEP) > 11'(Y_MAX)) ? 9'(Y_MAX) : cur_y + 9'(STEP);
        default: new_y = ({2'b00, cur_y} < 11'(Y_MIN + STEP)) ? 9'(Y_MIN) : cur_y - 9'(STEP);
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N_ANTS; i++) begin
      ant_x[10*i +: 10] = x_q[i];
      ant_y[9*i +: 9]   = y_q[i];
    end
  end

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      state_q     <= StIdle;
      vblank_q    <= 1'b0;
      wait_cnt_q  <= '0;
      dir_q       <= 2'b00;
      move_q      <= 1'b0;
      req         <= 1'b0;
      req_id      <= '0;
      busy        <= 1'b0;
      round_done  <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      for (int i = 0; i < N_ANTS; i++) begin
        x_q[i] <= 10'(100 * (i + 1));
        y_q[i] <= 9'(Y_MAX);
      end
    end else begin
      vblank_q   <= vblank;
      round_done <= 1'b0;
      // Later assignments to the flags override the clear, so a set wins.
      if (err_clr) begin
        err_timeout <= 1'b0;
        err_overrun <= 1'b0;
      end
      if (rise && state_q != StIdle) err_overrun <= 1'b1;
      case (state_q)
        StIdle: begin
          if (rise) begin
            state_q    <= StWait;
            req        <= 1'b1;
            req_id     <= '0;
            busy       <= 1'b1;
            wait_cnt_q <= '0;
          end
        end
        StWait: begin
          if (ack) begin
            dir_q   <= dir;
            move_q  <= move_en;
            req     <= 1'b0;
            state_q <= StApply;
          end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
            move_q      <= 1'b0;
            req         <= 1'b0;
            err_timeout <= 1'b1;
            state_q     <= StApply;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        StApply: begin
          x_q[req_id] <= new_x;
          y_q[req_id] <= new_y;
          if (req_id == IW'(N_ANTS - 1)) begin
            state_q    <= StIdle;
            busy       <= 1'b0;
            round_done <= 1'b1;
          end else begin
            req_id     <= req_id + IW'(1);
            req        <= 1'b1;
            wait_cnt_q <= '0;
            state_q    <= StWait;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
